// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of an 8 x 16-bit register bank
// between two requesters, each buffered by a one-entry slot.
module regbank_wr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [2:0]  req0_reg,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_reg,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        wr_en,
    output logic [2:0]  wr_reg,
    output logic [15:0] wr_data,
    output logic [7:0]  pending,
    output logic        last_grant
);

    logic        slot0_full_q, slot0_full_d;
    logic [2:0]  slot0_reg_q, slot0_reg_d;
    logic [15:0] slot0_data_q, slot0_data_d;
    logic        slot1_full_q, slot1_full_d;
    logic [2:0]  slot1_reg_q, slot1_reg_d;
    logic [15:0] slot1_data_q, slot1_data_d;
    logic        ptr_q, ptr_d;
    logic        last_grant_q, last_grant_d;
    logic        wr_en_q, wr_en_d;
    logic [2:0]  wr_reg_q, wr_reg_d;
    logic [15:0] wr_data_q, wr_data_d;

    logic grant0, grant1, load0, load1;

    always_comb begin
        grant0 = slot0_full_q && (!slot1_full_q || !ptr_q);
        grant1 = slot1_full_q && (!slot0_full_q || ptr_q);

        // A slot being drained this edge can accept a refill at the same edge.
        req0_ready = !slot0_full_q || grant0;
        req1_ready = !slot1_full_q || grant1;

        // Writes to register 0 are handshaken but never buffered.
        load0 = req0_valid && req0_ready && (req0_reg != '0);
        load1 = req1_valid && req1_ready && (req1_reg != '0);

        slot0_full_d = slot0_full_q;
        slot0_reg_d  = slot0_reg_q;
        slot0_data_d = slot0_data_q;
        slot1_full_d = slot1_full_q;
        slot1_reg_d  = slot1_reg_q;
        slot1_data_d = slot1_data_q;

        if (grant0) slot0_full_d = 1'b0;
        if (load0) begin
            slot0_full_d = 1'b1;
            slot0_reg_d  = req0_reg;
            slot0_data_d = req0_data;
        end
        if (grant1) slot1_full_d = 1'b0;
        if (load1) begin
            slot1_full_d = 1'b1;
            slot1_reg_d  = req1_reg;
            slot1_data_d = req1_data;
        end

        wr_en_d      = grant0 || grant1;
        wr_reg_d     = wr_reg_q;
        wr_data_d    = wr_data_q;
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        if (grant0) begin
            wr_reg_d     = slot0_reg_q;
            wr_data_d    = slot0_data_q;
            ptr_d        = 1'b1;
            last_grant_d = 1'b0;
        end else if (grant1) begin
            wr_reg_d     = slot1_reg_q;
            wr_data_d    = slot1_data_q;
            ptr_d        = 1'b0;
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_full_q <= 1'b0;
            slot0_reg_q  <= '0;
            slot0_data_q <= '0;
            slot1_full_q <= 1'b0;
            slot1_reg_q  <= '0;
            slot1_data_q <= '0;
            ptr_q        <= 1'b0;
            last_grant_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_reg_q     <= '0;
            wr_data_q    <= '0;
        end else begin
            slot0_full_q <= slot0_full_d;
            slot0_reg_q  <= slot0_reg_d;
            slot0_data_q <= slot0_data_d;
            slot1_full_q <= slot1_full_d;
            slot1_reg_q  <= slot1_reg_d;
            slot1_data_q <= slot1_data_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_reg_q     <= wr_reg_d;
            wr_data_q    <= wr_data_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned r = 1; r < 8; r++) begin
            pending[r] = (slot0_full_q && slot0_reg_q == 3'(r)) ||
                         (slot1_full_q && slot1_reg_q == 3'(r)) ||
                         (wr_en_q && wr_reg_q == 3'(r));
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_reg     = wr_reg_q;
    assign wr_data    = wr_data_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed self-checking bench for regbank_wr_arbiter with a behavioural bank sink.
module tb_regbank_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [2:0]  req0_reg = '0;
    logic [15:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [2:0]  req1_reg = '0;
    logic [15:0] req1_data = '0;
    logic        req1_ready;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic [7:0]  pending;
    logic        last_grant;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    logic [15:0] bank [8];

    regbank_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .pending(pending), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Bank sink: commits on the edge after wr_en is presented.
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            bank[wr_reg] <= wr_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int exp_r0 [7]  = '{1, 1, 0, 1, 0, 1, 0};
    int exp_r1 [7]  = '{1, 0, 1, 0, 1, 0, 1};
    int exp_en [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int exp_rg [13] = '{0, 0, 1, 2, 1, 2, 1, 2, 1, 2, 0, 0, 0};
    int exp_dt [13] = '{0, 0, 1, 'h11, 2, 'h12, 3, 'h13, 4, 'h14, 0, 0, 0};

    initial begin
        int idx0, idx1, snap;
        logic acc0, acc1;

        // Reset state
        tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ready0", req0_ready, 1);
        chk("rst_ready1", req1_ready, 1);
        chk("rst_last_grant", last_grant, 0);
        rst = 1'b0;

        // Lone write
        tick();
        req0_valid = 1'b1; req0_reg = 3'd3; req0_data = 16'hA5A5;
        #1;
        chk("lone_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("lone_wr_en_lat", wr_en, 0);
        chk("lone_pending_slot", pending, 8'h08);
        tick();
        chk("lone_wr_en", wr_en, 1);
        chk("lone_wr_reg", wr_reg, 3);
        chk("lone_wr_data", wr_data, 16'hA5A5);
        chk("lone_pending_port", pending, 8'h08);
        chk("lone_last_grant", last_grant, 0);
        tick();
        chk("lone_wr_en_off", wr_en, 0);
        chk("lone_pending_clr", pending, 0);
        chk("lone_wr_data_hold", wr_data, 16'hA5A5);
        chk("lone_bank3", bank[3], 16'hA5A5);

        // Contention, starting fresh with requester 0 at priority
        do_reset();
        idx0 = 0; idx1 = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            req0_valid = (idx0 < 4); req0_reg = 3'd1; req0_data = 16'(idx0 + 1);
            req1_valid = (idx1 < 4); req1_reg = 3'd2; req1_data = 16'(idx1 + 'h11);
            #1;
            if (cyc < 7) begin
                chk($sformatf("cont_ready0_c%0d", cyc), req0_ready, exp_r0[cyc]);
                chk($sformatf("cont_ready1_c%0d", cyc), req1_ready, exp_r1[cyc]);
            end
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
            if (acc0) idx0++;
            if (acc1) idx1++;
            chk($sformatf("cont_wr_en_c%0d", cyc + 1), wr_en, exp_en[cyc + 1]);
            if (exp_en[cyc + 1] != 0) begin
                chk($sformatf("cont_wr_reg_c%0d", cyc + 1), wr_reg, exp_rg[cyc + 1]);
                chk($sformatf("cont_wr_data_c%0d", cyc + 1), wr_data, exp_dt[cyc + 1]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_last_grant", last_grant, 1);
        chk("cont_bank1", bank[1], 16'h0004);
        chk("cont_bank2", bank[2], 16'h0014);

        // Same register with ptr=1: a lone req0 write first moves priority to req1
        req0_valid = 1'b1; req0_reg = 3'd6; req0_data = 16'h0606;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("same_pre_wr_reg", wr_reg, 6);
        req0_valid = 1'b1; req0_reg = 3'd5; req0_data = 16'h0001;
        req1_valid = 1'b1; req1_reg = 3'd5; req1_data = 16'h0002;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("same_pending", pending, 8'h20);
        chk("same_wr_en_idle", wr_en, 0);
        tick();
        chk("same_first_data", wr_data, 16'h0002);
        chk("same_first_grant", last_grant, 1);
        chk("same_pending_mid", pending, 8'h20);
        tick();
        chk("same_second_data", wr_data, 16'h0001);
        chk("same_second_grant", last_grant, 0);
        tick();
        chk("same_wr_en_off", wr_en, 0);
        chk("same_bank5", bank[5], 16'h0001);
        chk("same_pending_clr", pending, 0);

        // Zero register
        snap = wr_count;
        req1_valid = 1'b1; req1_reg = 3'd0; req1_data = 16'hFFFF;
        #1;
        chk("zero_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("zero_pending", pending, 0);
        chk("zero_ready1_after", req1_ready, 1);
        tick();
        chk("zero_wr_en", wr_en, 0);
        tick();
        chk("zero_wr_count", wr_count, snap);

        // Streaming from requester 0
        snap = wr_count;
        for (int i = 0; i < 10; i++) begin
            req0_valid = (i < 8); req0_reg = 3'((i % 7) + 1); req0_data = 16'('h100 + i);
            #1;
            if (i < 8) chk($sformatf("stream_ready0_%0d", i), req0_ready, 1);
            tick();
            if (i >= 1 && i <= 8) begin
                chk($sformatf("stream_wr_en_%0d", i), wr_en, 1);
                chk($sformatf("stream_wr_reg_%0d", i), wr_reg, ((i - 1) % 7) + 1);
                chk($sformatf("stream_wr_data_%0d", i), wr_data, 'h100 + i - 1);
            end else begin
                chk($sformatf("stream_wr_en_%0d", i), wr_en, 0);
            end
        end
        req0_valid = 1'b0;
        tick();
        chk("stream_wr_count", wr_count - snap, 8);

        // Mid-operation reset
        req0_valid = 1'b1; req0_reg = 3'd3; req0_data = 16'h0333;
        req1_valid = 1'b1; req1_reg = 3'd4; req1_data = 16'h0444;
        tick();
        req1_reg = 3'd7; req1_data = 16'h0777;
        #1;
        chk("midrst_ready0", req0_ready, 0);
        chk("midrst_ready1", req1_ready, 1);
        tick();
        chk("midrst_pre_wr_en", wr_en, 1);
        chk("midrst_pre_wr_reg", wr_reg, 4);
        chk("midrst_pre_pending", pending, 8'h98);
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_ready0_after", req0_ready, 1);
        chk("midrst_ready1_after", req1_ready, 1);
        chk("midrst_last_grant", last_grant, 0);
        snap = wr_count;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst_no_write", wr_count, snap);
        chk("midrst_wr_en_post", wr_en, 0);
        chk("midrst_pending_post", pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
